multicycle_controller: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. It drives the ALU's `ALUConf`/`Sign` inputs and every datapath mux and write enable. It sequences each instruction through IF/ID/EX/MEM/WB from the opcode/funct held in the external instruction register. It consumes the ALU `Zero` flag to resolve branches.

---
 rtl/multicycle_controller.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM for the multi-cycle MIPS datapath
//
// Sequences each instruction through IF/ID/EX/MEM/WB and decodes the datapath
// mux selects, write enables and ALU controls from the state and OpCode/Funct.
//
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN
//   defined   - undefined op/funct in ID enters TRAP and sets the sticky Illegal
//   undefined - undefined op/funct is a 2-cycle NOP, Illegal tied to 0
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   OpCode, Funct          IR[31:26], IR[5:0]
//   Zero                   ALU zero flag, used for beq/bne in EX
//   PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite
//                          write enables and memory address select
//   RegDst, MemtoReg       register file destination / write-back source
//   ALUSrcA, ALUSrcB       ALU operand selects
//   ALUConf, Sign          ALU operation and signed-compare select
//   ExtOp, LuiOp           immediate extension controls
//   PCSource               next-PC select
//   InstrDone              final cycle of an instruction
//   Illegal                sticky undefined-instruction flag

module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [4:0] ALUConf,
    output logic       Sign,
    output logic       ExtOp,
    output logic       LuiOp,
    output logic [1:0] PCSource,
    output logic       InstrDone,
    output logic       Illegal
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        S_WB   = 3'd4,
        S_TRAP = 3'd5
`else
        S_WB   = 3'd4
`endif
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_XOR = 5'b01101;
    localparam logic [4:0] ALU_SRL = 5'b10000;
    localparam logic [4:0] ALU_SRA = 5'b11000;
    localparam logic [4:0] ALU_SLL = 5'b11001;

    state_t state_q, state_d;

    // Instruction class decode
    logic is_r, r_jr, r_jalr, r_shift, r_alu, i_alu;
    logic is_lw, is_sw, is_beq, is_bne, is_j, is_jal, legal;

    always_comb begin
        is_r    = (OpCode == 6'h00);
        r_jr    = is_r && (Funct == 6'h08);
        r_jalr  = is_r && (Funct == 6'h09);
        r_shift = is_r && ((Funct == 6'h00) || (Funct == 6'h02) || (Funct == 6'h03));
        r_alu   = is_r && (((Funct >= 6'h20) && (Funct <= 6'h27)) ||
                           (Funct == 6'h2a) || (Funct == 6'h2b));
        i_alu   = ((OpCode >= 6'h08) && (OpCode <= 6'h0c)) || (OpCode == 6'h0f);
        is_lw   = (OpCode == 6'h23);
        is_sw   = (OpCode == 6'h2b);
        is_beq  = (OpCode == 6'h04);
        is_bne  = (OpCode == 6'h05);
        is_j    = (OpCode == 6'h02);
        is_jal  = (OpCode == 6'h03);
        legal   = r_jr | r_jalr | r_shift | r_alu | i_alu | is_lw | is_sw |
                  is_beq | is_bne | is_j | is_jal;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = S_IF;
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 2'b00;
        MemtoReg  = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUConf   = ALU_ADD;
        Sign      = 1'b1;
        ExtOp     = 1'b1;
        LuiOp     = 1'b0;
        PCSource  = 2'b00;
        InstrDone = 1'b0;

        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
                state_d = S_ID;
            end
            S_ID: begin
                // ALUOut captures PC+4 + (imm<<2) for a possible branch in EX
                ALUSrcB = 2'b11;
                state_d = S_EX;
                if (is_j || is_jal) begin
                    PCWrite   = 1'b1;
                    PCSource  = 2'b10;
                    InstrDone = 1'b1;
                    state_d   = S_IF;
                    if (is_jal) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end
                end else if (r_jr || r_jalr) begin
                    PCWrite   = 1'b1;
                    PCSource  = 2'b11;
                    InstrDone = 1'b1;
                    state_d   = S_IF;
                    if (r_jalr) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b01;
                        MemtoReg = 2'b10;
                    end
                end else if (!legal) begin
                    InstrDone = 1'b1;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    state_d   = S_TRAP;
`else
                    state_d   = S_IF;
`endif
                end
            end
            S_EX: begin
                state_d = S_WB;
                if (r_alu) begin
                    ALUSrcA = 2'b01;
                    case (Funct)
                        6'h22, 6'h23: ALUConf = ALU_SUB;
                        6'h24:        ALUConf = ALU_AND;
                        6'h25:        ALUConf = ALU_OR;
                        6'h26:        ALUConf = ALU_XOR;
                        6'h27:        ALUConf = ALU_NOR;
                        6'h2a:        ALUConf = ALU_SLT;
                        6'h2b: begin
                            ALUConf = ALU_SLT;
                            Sign    = 1'b0;
                        end
                        default:      ALUConf = ALU_ADD;
                    endcase
                end else if (r_shift) begin
                    ALUSrcA = 2'b10;
                    case (Funct)
                        6'h02:   ALUConf = ALU_SRL;
                        6'h03:   ALUConf = ALU_SRA;
                        default: ALUConf = ALU_SLL;
                    endcase
                end else if (i_alu) begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    case (OpCode)
                        6'h0a:   ALUConf = ALU_SLT;
                        6'h0b: begin
                            ALUConf = ALU_SLT;
                            Sign    = 1'b0;
                        end
                        6'h0c: begin
                            ALUConf = ALU_AND;
                            ExtOp   = 1'b0;
                        end
                        6'h0f: begin
                            ALUConf = ALU_OR;
                            LuiOp   = 1'b1;
                        end
                        default: ALUConf = ALU_ADD;
                    endcase
                end else if (is_lw || is_sw) begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    state_d = S_MEM;
                end else if (is_beq || is_bne) begin
                    // The only Mealy output: branch decision taken straight from Zero
                    ALUSrcA   = 2'b01;
                    ALUConf   = ALU_SUB;
                    PCSource  = 2'b01;
                    InstrDone = 1'b1;
                    PCWrite   = is_beq ? Zero : ~Zero;
                    state_d   = S_IF;
                end else begin
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                IorD = 1'b1;
                if (is_lw) begin
                    MemRead = 1'b1;
                    state_d = S_WB;
                end else begin
                    MemWrite  = is_sw;
                    InstrDone = is_sw;
                    state_d   = S_IF;
                end
            end
            S_WB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                RegDst    = is_r ? 2'b01 : 2'b00;
                MemtoReg  = is_lw ? 2'b01 : 2'b00;
                state_d   = S_IF;
            end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_IF;
            end
        endcase

        // Reset forces state to IF asynchronously; also mask every enable so an
        // aborted instruction cannot complete a partial write in this cycle.
        if (!reset_n) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            InstrDone = 1'b0;
        end
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign Illegal = illegal_q;
`else
    assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking scoreboard bench for multicycle_controller

module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [4:0] conf;
        logic       sign;
        logic       ext;
        logic       lui;
        logic [1:0] pcs;
        logic       done;
        logic       ill;
    } ctl_t;

    localparam int K_R   = 0;
    localparam int K_SH  = 1;
    localparam int K_I   = 2;
    localparam int K_LW  = 3;
    localparam int K_SW  = 4;
    localparam int K_BR  = 5;
    localparam int K_J   = 6;
    localparam int K_JR  = 7;
    localparam int K_NOP = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic [4:0] ALUConf;
    logic       Sign, ExtOp, LuiOp, InstrDone, Illegal;

    ctl_t dut_v;
    ctl_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .OpCode    (OpCode),
        .Funct     (Funct),
        .Zero      (Zero),
        .PCWrite   (PCWrite),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUConf   (ALUConf),
        .Sign      (Sign),
        .ExtOp     (ExtOp),
        .LuiOp     (LuiOp),
        .PCSource  (PCSource),
        .InstrDone (InstrDone),
        .Illegal   (Illegal)
    );

    assign dut_v = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
                    ALUSrcA, ALUSrcB, ALUConf, Sign, ExtOp, LuiOp, PCSource, InstrDone, Illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t v_dflt();
        ctl_t e;
        e      = '0;
        e.sign = 1'b1;
        e.ext  = 1'b1;
        return e;
    endfunction

    function automatic ctl_t v_if();
        ctl_t e;
        e     = v_dflt();
        e.pcw = 1'b1;
        e.mr  = 1'b1;
        e.irw = 1'b1;
        e.sb  = 2'b01;
        return e;
    endfunction

    function automatic ctl_t v_rst();
        ctl_t e;
        e     = v_if();
        e.pcw = 1'b0;
        e.mr  = 1'b0;
        e.irw = 1'b0;
        return e;
    endfunction

    // Pushes the expected per-cycle control vectors for one instruction, then
    // pops and compares one entry per cycle until the instruction is drained.
    task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int kind, input logic [4:0] conf, input logic sg, input logic ex,
                       input logic lu, input logic flag);
        ctl_t e;
        int   cyc;
        OpCode = op;
        Funct  = fn;
        Zero   = z;
        sb_q.push_back(v_if());
        e    = v_dflt();
        e.sb = 2'b11;
        case (kind)
            K_J, K_JR: begin
                e.pcw  = 1'b1;
                e.pcs  = (kind == K_J) ? 2'b10 : 2'b11;
                e.done = 1'b1;
                if (flag) begin
                    e.rw  = 1'b1;
                    e.rd  = (kind == K_J) ? 2'b10 : 2'b01;
                    e.m2r = 2'b10;
                end
                sb_q.push_back(e);
            end
            K_NOP: begin
                e.done = 1'b1;
                sb_q.push_back(e);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                e     = v_dflt();
                e.ill = 1'b1;
                repeat (3) sb_q.push_back(e);
`endif
            end
            default: begin
                sb_q.push_back(e);
                e      = v_dflt();
                e.conf = conf;
                e.sign = sg;
                e.ext  = ex;
                e.lui  = lu;
                case (kind)
                    K_R:  e.sa = 2'b01;
                    K_SH: e.sa = 2'b10;
                    K_I, K_LW, K_SW: begin
                        e.sa = 2'b01;
                        e.sb = 2'b10;
                    end
                    K_BR: begin
                        e.sa   = 2'b01;
                        e.pcs  = 2'b01;
                        e.done = 1'b1;
                        e.pcw  = flag;
                    end
                    default: ;
                endcase
                sb_q.push_back(e);
                if (kind == K_LW || kind == K_SW) begin
                    e      = v_dflt();
                    e.iord = 1'b1;
                    if (kind == K_LW) begin
                        e.mr = 1'b1;
                    end else begin
                        e.mw   = 1'b1;
                        e.done = 1'b1;
                    end
                    sb_q.push_back(e);
                end
                if (kind != K_SW && kind != K_BR) begin
                    e      = v_dflt();
                    e.rw   = 1'b1;
                    e.done = 1'b1;
                    e.rd   = (kind == K_R || kind == K_SH) ? 2'b01 : 2'b00;
                    e.m2r  = (kind == K_LW) ? 2'b01 : 2'b00;
                    sb_q.push_back(e);
                end
            end
        endcase
        cyc = 0;
        while (sb_q.size() > 0) begin
            #1;
            e = sb_q.pop_front();
            check($sformatf("%s.c%0d", nm, cyc), 32'(dut_v), 32'(e));
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        OpCode  = 6'h00;
        Funct   = 6'h20;
        Zero    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset", 32'(dut_v), 32'(v_rst()));
        reset_n = 1'b1;

        run("add",   6'h00, 6'h20, 1'b0, K_R,  5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        run("sll",   6'h00, 6'h00, 1'b0, K_SH, 5'b11001, 1'b1, 1'b1, 1'b0, 1'b0);
        run("srl",   6'h00, 6'h02, 1'b0, K_SH, 5'b10000, 1'b1, 1'b1, 1'b0, 1'b0);
        run("sra",   6'h00, 6'h03, 1'b0, K_SH, 5'b11000, 1'b1, 1'b1, 1'b0, 1'b0);
        run("sub",   6'h00, 6'h22, 1'b0, K_R,  5'b00110, 1'b1, 1'b1, 1'b0, 1'b0);
        run("xor",   6'h00, 6'h26, 1'b0, K_R,  5'b01101, 1'b1, 1'b1, 1'b0, 1'b0);
        run("nor",   6'h00, 6'h27, 1'b0, K_R,  5'b01100, 1'b1, 1'b1, 1'b0, 1'b0);
        run("slt",   6'h00, 6'h2a, 1'b0, K_R,  5'b00111, 1'b1, 1'b1, 1'b0, 1'b0);
        run("sltu",  6'h00, 6'h2b, 1'b0, K_R,  5'b00111, 1'b0, 1'b1, 1'b0, 1'b0);
        run("lw",    6'h23, 6'h00, 1'b0, K_LW, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        run("sw",    6'h2b, 6'h00, 1'b0, K_SW, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        run("beq_t", 6'h04, 6'h00, 1'b1, K_BR, 5'b00110, 1'b1, 1'b1, 1'b0, 1'b1);
        run("beq_n", 6'h04, 6'h00, 1'b0, K_BR, 5'b00110, 1'b1, 1'b1, 1'b0, 1'b0);
        run("bne_n", 6'h05, 6'h00, 1'b1, K_BR, 5'b00110, 1'b1, 1'b1, 1'b0, 1'b0);
        run("bne_t", 6'h05, 6'h00, 1'b0, K_BR, 5'b00110, 1'b1, 1'b1, 1'b0, 1'b1);
        run("addi",  6'h08, 6'h00, 1'b0, K_I,  5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        run("slti",  6'h0a, 6'h00, 1'b0, K_I,  5'b00111, 1'b1, 1'b1, 1'b0, 1'b0);
        run("sltiu", 6'h0b, 6'h00, 1'b0, K_I,  5'b00111, 1'b0, 1'b1, 1'b0, 1'b0);
        run("andi",  6'h0c, 6'h00, 1'b0, K_I,  5'b00010, 1'b1, 1'b0, 1'b0, 1'b0);
        run("lui",   6'h0f, 6'h00, 1'b0, K_I,  5'b00001, 1'b1, 1'b1, 1'b1, 1'b0);
        run("j",     6'h02, 6'h00, 1'b0, K_J,  5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        run("jal",   6'h03, 6'h00, 1'b0, K_J,  5'b00000, 1'b1, 1'b1, 1'b0, 1'b1);
        run("jr",    6'h00, 6'h08, 1'b0, K_JR, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        run("jalr",  6'h00, 6'h09, 1'b0, K_JR, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b1);

        // Reset pulsed while sw is in MEM: write must drop in the same cycle
        OpCode = 6'h2b;
        Funct  = 6'h00;
        repeat (3) @(negedge clk);
        #1;
        check("swrst.memw", 32'(MemWrite), 32'd1);
        reset_n = 1'b0;
        #1;
        check("swrst.abort", 32'(dut_v), 32'(v_rst()));
        @(negedge clk);
        reset_n = 1'b1;
        run("add_post_rst", 6'h00, 6'h21, 1'b0, K_R, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);

        // Undefined opcode: NOP by default, sticky trap with the feature enabled
        run("op3f",  6'h3f, 6'h00, 1'b0, K_NOP, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        reset_n = 1'b0;
        #1;
        check("trap.clr", 32'(Illegal), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
`endif
        run("sw_end", 6'h2b, 6'h00, 1'b0, K_SW, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
